// File: rtl/kbd_pkg.sv
// Shared PS/2 keyboard definitions: scancode constants, frame-state enum and
// the odd-parity helper used by the receiver.
package kbd_pkg;

  localparam int unsigned BYTE_W = 8;

  // Prefix bytes and the final codes this decoder tracks.
  localparam logic [BYTE_W-1:0] SC_EXT   = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_BRK   = 8'hF0;
  localparam logic [BYTE_W-1:0] SC_SPACE = 8'h29;
  localparam logic [BYTE_W-1:0] SC_LEFT  = 8'h6B;
  localparam logic [BYTE_W-1:0] SC_RIGHT = 8'h74;

  // Position within one 11-bit PS/2 frame.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  // True when data plus parity carries an odd number of ones.
  function automatic logic odd_parity_ok(input logic [BYTE_W-1:0] data,
                                         input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes both lines, glitch-filters the clock,
// shifts in start/data/parity/stop bits and guards the frame with a timeout.
// Emits the received byte with single-cycle accept and error strobes in the
// cycle of the stop-bit edge, so the consumer can register them one cycle on.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad parity.
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter int unsigned FILT_LEN   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk_i,
  input  logic              ps2_data_i,
  output logic [BYTE_W-1:0] rx_byte_o,
  output logic              rx_valid_c,
  output logic              rx_err_c
);

  localparam int unsigned TO_LIMIT = (CLK_FREQ / 1_000_000) * TIMEOUT_US;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);
  localparam int unsigned FC_W     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned BC_W     = 3;

  logic              clk_meta_q, clk_sync_q;
  logic              dat_meta_q, dat_sync_q;
  logic              filt_q, filt_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              fall_c;
  logic              expire_c;
  logic              par_ok_c;
  logic              stop_edge_c;
  frame_state_e      state_q;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [BYTE_W-1:0] shift_q;

  // Two-flop synchronizers; both lines rest high like an idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data_i;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Filter next state: flip only on the FILT_LEN-th consecutive differing sample.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    fall_c = 1'b0;
    if (clk_sync_q == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FC_W'(FILT_LEN - 1)) begin
      filt_d = clk_sync_q;
      fcnt_d = '0;
      fall_c = filt_q;
    end else begin
      fcnt_d = fcnt_q + FC_W'(1);
    end
  end

  // Glitch-filter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Inter-edge timeout: cleared by each falling edge, saturating at the limit.
  always_comb begin
    to_d     = to_q;
    expire_c = 1'b0;
    if (fall_c) begin
      to_d = '0;
    end else if (to_q != TO_W'(TO_LIMIT)) begin
      to_d     = to_q + TO_W'(1);
      expire_c = (to_q == TO_W'(TO_LIMIT - 1));
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end

  // Frame FSM; an edge in the expiry cycle takes priority over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (fall_c) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!dat_sync_q) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
          end
        end
        ST_DATA: begin
          shift_q   <= {dat_sync_q, shift_q[BYTE_W-1:1]};
          bit_cnt_q <= bit_cnt_q + BC_W'(1);
          if (bit_cnt_q == BC_W'(BYTE_W - 1)) begin
            state_q <= ST_PARITY;
          end
        end
        ST_PARITY: state_q <= ST_STOP;
        ST_STOP:   state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end else if (expire_c && (state_q != ST_IDLE)) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_q;

  // Capture the parity bit so it can be judged at the stop edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (fall_c && (state_q == ST_PARITY)) begin
      par_q <= dat_sync_q;
    end
  end

  // Odd parity over data plus parity bit.
  always_comb begin
    par_ok_c = odd_parity_ok(shift_q, par_q);
  end
`else
  // The parity bit is clocked through the PARITY state but not judged.
  always_comb begin
    par_ok_c = 1'b1;
  end
`endif

  // Accept/discard strobes, asserted in the stop-edge or expiry cycle.
  always_comb begin
    stop_edge_c = fall_c && (state_q == ST_STOP);
    rx_valid_c  = stop_edge_c && dat_sync_q && par_ok_c;
    rx_err_c    = (stop_edge_c && !(dat_sync_q && par_ok_c)) ||
                  (expire_c && (state_q != ST_IDLE));
  end

  assign rx_byte_o = shift_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: receives scancode bytes via ps2_rx and tracks the
// E0/F0 prefixes to maintain held levels for space, left and right arrow.
// Build option: PS2_PARITY_CHECK_EN (parity checking inside ps2_rx).
module ps2_key_decoder
  import kbd_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter int unsigned FILT_LEN   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic              key_space,
  output logic              key_left,
  output logic              key_right,
  output logic [BYTE_W-1:0] scancode,
  output logic              scancode_valid,
  output logic              frame_err
);

  logic [BYTE_W-1:0] rx_byte;
  logic              rx_valid_c;
  logic              rx_err_c;

  logic [BYTE_W-1:0] scancode_q, scancode_d;
  logic              valid_q, err_q;
  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic              space_q, space_d;
  logic              left_q, left_d;
  logic              right_q, right_d;

  ps2_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .TIMEOUT_US (TIMEOUT_US),
    .FILT_LEN   (FILT_LEN)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .rx_byte_o  (rx_byte),
    .rx_valid_c (rx_valid_c),
    .rx_err_c   (rx_err_c)
  );

  // Make/break decode: prefixes set flags, a final code applies and clears them.
  always_comb begin
    scancode_d = scancode_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    space_d    = space_q;
    left_d     = left_q;
    right_d    = right_q;
    if (rx_valid_c) begin
      scancode_d = rx_byte;
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        if ((rx_byte == SC_SPACE) && !ext_q) space_d = !brk_q;
        if ((rx_byte == SC_LEFT)  &&  ext_q) left_d  = !brk_q;
        if ((rx_byte == SC_RIGHT) &&  ext_q) right_d = !brk_q;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // Output and flag registers; keys move together with scancode_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      scancode_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      space_q    <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
    end else begin
      scancode_q <= scancode_d;
      valid_q    <= rx_valid_c;
      err_q      <= rx_err_c;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      space_q    <= space_d;
      left_q     <= left_d;
      right_q    <= right_d;
    end
  end

  assign scancode       = scancode_q;
  assign scancode_valid = valid_q;
  assign frame_err      = err_q;
  assign key_space      = space_q;
  assign key_left       = left_q;
  assign key_right      = right_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: drives PS/2 frames, predicts each accepted byte,
// error and key level from the protocol rules, and checks every cycle.
module tb_ps2_key_decoder;

  localparam int unsigned CLK_FREQ   = 1_000_000;
  localparam int unsigned TIMEOUT_US = 300;
  localparam int unsigned FILT_LEN   = 4;
  localparam int LIMIT    = int'(CLK_FREQ / 1_000_000 * TIMEOUT_US);
  localparam int HALF     = 20;
  localparam int EDGE_LAT = 2 + int'(FILT_LEN);  // sync + filter samples

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_space, key_left, key_right;
  logic [7:0] scancode;
  logic       scancode_valid, frame_err;

  ps2_key_decoder #(
    .CLK_FREQ   (CLK_FREQ),
    .TIMEOUT_US (TIMEOUT_US),
    .FILT_LEN   (FILT_LEN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .key_space      (key_space),
    .key_left       (key_left),
    .key_right      (key_right),
    .scancode       (scancode),
    .scancode_valid (scancode_valid),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int valid_pulses = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!rst && scancode_valid) valid_pulses <= valid_pulses + 1;

  typedef struct {
    int         due;
    logic [7:0] code;
    logic [2:0] keys;  // {right, left, space}
  } ev_t;

  ev_t vq[$];
  int  eq[$];

  // Protocol-level model of the key state.
  logic [2:0] m_keys = '0;
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic [2:0] exp_keys = '0;
  logic [7:0] exp_sc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply one accepted byte to the model and schedule its visible effect.
  task automatic model_byte(input logic [7:0] b, input int due);
    ev_t ev;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (b == 8'h29 && !m_ext) m_keys[0] = !m_brk;
      if (b == 8'h6B &&  m_ext) m_keys[1] = !m_brk;
      if (b == 8'h74 &&  m_ext) m_keys[2] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    ev.due  = due;
    ev.code = b;
    ev.keys = m_keys;
    vq.push_back(ev);
  endtask

  // Per-cycle comparison against the scheduled expectations.
  always @(negedge clk) begin
    bit exp_v;
    bit exp_e;
    if (chk_en && !rst) begin
      exp_v = 1'b0;
      exp_e = 1'b0;
      if (vq.size() > 0 && vq[0].due == cyc) begin
        exp_v    = 1'b1;
        exp_sc   = vq[0].code;
        exp_keys = vq[0].keys;
        vq.delete(0);
      end
      if (eq.size() > 0 && eq[0] == cyc) begin
        exp_e = 1'b1;
        eq.delete(0);
      end
      check("scancode_valid", 32'(scancode_valid), 32'(exp_v));
      check("frame_err", 32'(frame_err), 32'(exp_e));
      check("scancode", 32'(scancode), 32'(exp_sc));
      check("keys", 32'({key_right, key_left, key_space}), 32'(exp_keys));
    end
  end

  // One PS/2 bit: data set while clock high, then a low half period.
  task automatic ps2_bit(input logic d, output int fall_cyc);
    ps2_data = d;
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int   fc;
    logic par;
    bit   accept;
    par = (~^b) ^ bad_par;
    ps2_bit(1'b0, fc);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], fc);
    ps2_bit(par, fc);
    ps2_data = !bad_stop;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    fc = cyc;
    accept = !bad_stop;
`ifdef PS2_PARITY_CHECK_EN
    accept = accept && !bad_par;
`endif
    if (accept) model_byte(b, fc + EDGE_LAT);
    else eq.push_back(fc + EDGE_LAT);
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask

  // Start bit plus (n-1) data bits, then silence.
  task automatic send_partial(input int n, output int last_fall);
    logic [7:0] pat;
    pat = 8'hA5;
    ps2_bit(1'b0, last_fall);
    for (int i = 0; i < n - 1; i++) ps2_bit(pat[i], last_fall);
    ps2_data = 1'b1;
  endtask

  initial begin
    int lf;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("reset scancode", 32'(scancode), 32'h0);
    check("reset valid", 32'(scancode_valid), 32'h0);
    check("reset err", 32'(frame_err), 32'h0);
    check("reset keys", 32'({key_right, key_left, key_space}), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // Space press.
    send_frame(8'h29, 1'b0, 1'b0);
    check("space make", 32'(key_space), 32'h1);
    check("space code", 32'(scancode), 32'h29);
    check("one valid pulse", 32'(valid_pulses), 32'h1);

    // Space release.
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0);
    check("space break", 32'({key_right, key_left, key_space}), 32'h0);

    // Left and right held together, then left released.
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h6B, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0);
    check("left+right", 32'({key_right, key_left, key_space}), 32'h6);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h6B, 1'b0, 1'b0);
    check("left break", 32'({key_right, key_left, key_space}), 32'h4);

    // Non-extended 6B touches no key.
    send_frame(8'h6B, 1'b0, 1'b0);
    check("plain 6B code", 32'(scancode), 32'h6B);
    check("plain 6B keys", 32'({key_right, key_left, key_space}), 32'h4);

    // Truncated frame times out, then a normal frame and a typematic repeat.
    send_partial(4, lf);
    eq.push_back(lf + EDGE_LAT + LIMIT);
    repeat (2 * LIMIT) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b0);
    check("space after timeout", 32'(key_space), 32'h1);
    send_frame(8'h29, 1'b0, 1'b0);
    check("space typematic", 32'(key_space), 32'h1);

    // Release, then a space frame with wrong parity.
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("bad parity space", 32'(key_space), 32'h0);
`else
    check("bad parity space", 32'(key_space), 32'h1);
`endif

    // Bad stop bit: discarded, scancode keeps the last accepted byte.
    send_frame(8'h6B, 1'b0, 1'b1);
    check("bad stop code", 32'(scancode), 32'h29);

    // Reset mid-frame: no error afterwards, everything back to zero.
    send_partial(5, lf);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    vq.delete();
    eq.delete();
    m_keys = '0; m_ext = 1'b0; m_brk = 1'b0;
    exp_keys = '0; exp_sc = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * LIMIT) @(negedge clk);
    check("post-reset keys", 32'({key_right, key_left, key_space}), 32'h0);
    send_frame(8'h29, 1'b0, 1'b0);
    check("post-reset space", 32'(key_space), 32'h1);

    check("pending events", 32'(vq.size() + eq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter TIMEOUT_US, default 2000, meaning the maximum gap in microseconds between PS/2 falling edges inside one frame.
REQ-003 The block SHALL have parameter FILT_LEN, default 8, meaning the number of consecutive equal samples required to accept a ps2_clk level.
REQ-004 Port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port ps2_clk, input, 1 bit: asynchronous PS/2 clock from the keyboard.
REQ-007 Port ps2_data, input, 1 bit: asynchronous PS/2 data from the keyboard.
REQ-008 Port key_space, output, 1 bit: high while the space key is held.
REQ-009 Port key_left, output, 1 bit: high while the left-arrow key is held.
REQ-010 Port key_right, output, 1 bit: high while the right-arrow key is held.
REQ-011 Port scancode, output, 8 bits: the last accepted byte.
REQ-012 Port scancode_valid, output, 1 bit: one-cycle pulse when scancode updates.
REQ-013 Port frame_err, output, 1 bit: one-cycle pulse on any discarded frame.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer.
- The synchronized ps2_clk SHALL then be glitch-filtered.
- The filtered level SHALL change only after FILT_LEN consecutive identical samples.
REQ-015 A falling edge SHALL be a filtered ps2_clk transition from 1 to 0; the synchronized ps2_data SHALL be sampled in that same cycle.
REQ-016 The frame FSM SHALL have states IDLE, DATA, PARITY, STOP.
- IDLE -> DATA on an edge with data=0; an edge with data=1 keeps IDLE.
- DATA: shift in 8 bits LSB first, then go to PARITY.
- PARITY -> STOP on the next edge.
- STOP -> IDLE on the next edge.
REQ-017 At STOP, data=1 SHALL accept the byte. Data=0 SHALL discard the byte and pulse frame_err.
REQ-018 A timeout counter SHALL clear on every falling edge and count otherwise. Its limit is CLK_FREQ/1_000_000*TIMEOUT_US cycles.
REQ-019 If the timeout limit is reached in any state other than IDLE:
- the FSM SHALL return to IDLE;
- the partial byte SHALL be dropped;
- frame_err SHALL pulse once.
REQ-020 If a falling edge and timeout expiry occur in the same cycle, the edge SHALL win and no error SHALL be raised.
REQ-021 An accepted byte SHALL drive scancode and pulse scancode_valid in the cycle after the stop-bit edge.
REQ-022 The decoder SHALL keep two flags, ext and brk.
- Byte E0 sets ext.
- Byte F0 sets brk.
- Any other byte is a final code: it clears both flags after being applied.
REQ-023 A final code SHALL update the key levels as follows, with level = not brk:
- 29 with ext=0 sets key_space.
- 6B with ext=1 sets key_left.
- 74 with ext=1 sets key_right.
- Any other final code changes no key.
REQ-024 Key outputs SHALL be registered and update in the same cycle as scancode_valid. They SHALL be stable between updates.
REQ-025 Several keys MAY be high at once. Typematic repeats of a make code SHALL leave the level at 1.

Reset
REQ-026 Reset SHALL set the following:
- FSM to IDLE; bit counter, shift register, timeout counter, ext and brk to 0;
- all outputs to 0;
- filter state and synchronizers to 1 (bus idle level).
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no frame_err pulse.

Configuration
REQ-028 With macro PS2_PARITY_CHECK_EN defined:
- the parity bit SHALL be checked for odd parity over the 8 data bits plus parity;
- a mismatch SHALL discard the byte at STOP and pulse frame_err.
REQ-029 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored.

Structure
REQ-030 A shared package kbd_pkg SHALL hold:
- the scancode constants SC_EXT=E0, SC_BRK=F0, SC_SPACE=29, SC_LEFT=6B, SC_RIGHT=74;
- the frame-state enum typedef.
REQ-031 Synchronizer, filter, frame FSM, timeout and parity SHALL live in sub-module ps2_rx. ps2_rx outputs byte plus a valid pulse plus an error pulse.
REQ-032 ps2_key_decoder SHALL instantiate ps2_rx and hold the make/break decode logic.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- Frame 29 with correct parity and stop -> scancode=29, scancode_valid one pulse, key_space=1 one cycle later than the stop edge plus filter/sync latency.
- Sequence F0,29 after a space press -> key_space returns to 0; key_left and key_right stay 0.
- Sequence E0,6B, then E0,74 -> key_left=1 and key_right=1 simultaneously. Then E0,F0,6B -> key_left=0 and key_right=1.
- Non-extended 6B -> no key change; scancode=6B, scancode_valid pulses.
- 4 bits then idle for more than 2 ms -> frame_err one pulse, FSM IDLE; the next valid frame 29 is decoded correctly.
- With PS2_PARITY_CHECK_EN, frame 29 with wrong parity -> frame_err pulse, no scancode_valid, key_space unchanged. Without the macro -> key_space=1.
